// File: rtl/iterative_alu.sv
// rtl/iterative_alu.sv - ALU with single-cycle logic/arith ops and iterative MUL/DIV
module iterative_alu #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       alu_op,
  input  logic             unsigned_op,
  input  logic [SHW-1:0]   shamt,
  input  logic [WIDTH-1:0] operand1,
  input  logic [WIDTH-1:0] operand2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             zero_signal,
  output logic             div_by_zero
);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_MUL  = 4'b0011;
  localparam logic [3:0] OP_NOR  = 4'b0100;
  localparam logic [3:0] OP_SLL  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_SRL  = 4'b1000;
  localparam logic [3:0] OP_SLTU = 4'b1001;
  localparam logic [3:0] OP_DIV  = 4'b1010;
  localparam logic [3:0] OP_SRA  = 4'b1011;
  localparam int         CW      = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] acc_hi;    // MUL: partial product high half; DIV: partial remainder
  logic [WIDTH-1:0] acc_lo;    // MUL: multiplier shifting out; DIV: dividend shifting into quotient
  logic [WIDTH-1:0] b_mag;     // multiplicand / divisor magnitude
  logic [CW-1:0]    step_cnt;
  logic             is_div;
  logic             neg_lo;    // negate product, or negate quotient
  logic             neg_hi;    // negate remainder (dividend was negative)

  logic [WIDTH-1:0]   op_res;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag_in;
  logic [WIDTH:0]     mul_sum, div_sh, div_diff;
  logic               div_ok;
  logic [WIDTH-1:0]   step_hi, step_lo, fin_hi, fin_lo;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic               is_iter;

  // Single-cycle operation results
  always_comb begin
    op_res = '0;
    case (alu_op)
      OP_AND:  op_res = operand1 & operand2;
      OP_OR:   op_res = operand1 | operand2;
      OP_ADD:  op_res = operand1 + operand2;
      OP_SUB:  op_res = operand1 - operand2;
      OP_NOR:  op_res = ~(operand1 | operand2);
      OP_SLT:  op_res = unsigned_op ? {{(WIDTH-1){1'b0}}, (operand1 < operand2)}
                                    : {{(WIDTH-1){1'b0}}, ($signed(operand1) < $signed(operand2))};
      OP_SLTU: op_res = {{(WIDTH-1){1'b0}}, (operand1 < operand2)};
      OP_SLL:  op_res = operand2 << shamt;
      OP_SRL:  op_res = operand2 >> shamt;
      OP_SRA:  op_res = $signed(operand2) >>> shamt;
      default: op_res = '0;
    endcase
  end

  // Operand magnitudes and one shift-add / restoring-subtract step, plus final sign fix
  always_comb begin
    a_neg    = ~unsigned_op & operand1[WIDTH-1];
    b_neg    = ~unsigned_op & operand2[WIDTH-1];
    a_mag    = a_neg ? -operand1 : operand1;
    b_mag_in = b_neg ? -operand2 : operand2;
    is_iter  = (alu_op == OP_MUL) || ((alu_op == OP_DIV) && (operand2 != '0));

    mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, b_mag} : {(WIDTH+1){1'b0}});
    div_sh   = {acc_hi, acc_lo[WIDTH-1]};
    div_diff = div_sh - {1'b0, b_mag};
    div_ok   = ~div_diff[WIDTH];

    if (is_div) begin
      step_hi = div_ok ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0];
      step_lo = {acc_lo[WIDTH-2:0], div_ok};
    end else begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
    end

    prod     = {step_hi, step_lo};
    prod_fix = neg_lo ? -prod : prod;
    if (is_div) begin
      fin_lo = neg_lo ? -step_lo : step_lo;
      fin_hi = neg_hi ? -step_hi : step_hi;
    end else begin
      fin_lo = prod_fix[WIDTH-1:0];
      fin_hi = prod_fix[2*WIDTH-1:WIDTH];
    end
  end

  // Control FSM with registered outputs; EXEC runs WIDTH steps, start ignored while busy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      result      <= '0;
      result_hi   <= '0;
      zero_signal <= 1'b1;
      div_by_zero <= 1'b0;
      acc_hi      <= '0;
      acc_lo      <= '0;
      b_mag       <= '0;
      step_cnt    <= '0;
      is_div      <= 1'b0;
      neg_lo      <= 1'b0;
      neg_hi      <= 1'b0;
    end else begin
      case (state)
        S_EXEC: begin
          acc_hi   <= step_hi;
          acc_lo   <= step_lo;
          step_cnt <= step_cnt + 1'b1;
          if (step_cnt == CW'(WIDTH-1)) begin
            state       <= S_DONE;
            busy        <= 1'b0;
            done        <= 1'b1;
            result      <= fin_lo;
            result_hi   <= fin_hi;
            zero_signal <= (fin_lo == '0);
            div_by_zero <= 1'b0;
          end
        end
        default: begin
          done <= 1'b0;
          if (start) begin
            if (is_iter) begin
              state    <= S_EXEC;
              busy     <= 1'b1;
              step_cnt <= '0;
              is_div   <= (alu_op == OP_DIV);
              acc_hi   <= '0;
              acc_lo   <= a_mag;
              b_mag    <= b_mag_in;
              neg_lo   <= a_neg ^ b_neg;
              neg_hi   <= a_neg;
            end else begin
              state <= S_DONE;
              done  <= 1'b1;
              if (alu_op == OP_DIV) begin
                result      <= '1;
                result_hi   <= operand1;
                zero_signal <= 1'b0;
                div_by_zero <= 1'b1;
              end else begin
                result      <= op_res;
                result_hi   <= '0;
                zero_signal <= (op_res == '0);
                div_by_zero <= 1'b0;
              end
            end
          end else begin
            state <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: doc/iterative_alu.md
ITERATIVE_ALU -- requirements
Module: iterative_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width; legal values 8..64, even.
REQ-002 SHALL have parameter SHW, default $clog2(WIDTH), shift-amount width.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port start  input  1  request; sampled only when busy=0.
REQ-006 SHALL have port alu_op  input  4  operation select, captured with start.
REQ-007 SHALL have port unsigned_op  input  1  1 = unsigned SLT/MUL/DIV, captured with start.
REQ-008 SHALL have port shamt  input  SHW  shift amount, captured with start.
REQ-009 SHALL have ports operand1, operand2  input  WIDTH each  operands, captured with start.
REQ-010 SHALL have port busy  output  1  high while an iterative op executes.
REQ-011 SHALL have port done  output  1  one-cycle pulse: result valid.
REQ-012 SHALL have port result  output  WIDTH  primary result (low product / quotient).
REQ-013 SHALL have port result_hi  output  WIDTH  high product / remainder; 0 for other ops.
REQ-014 SHALL have ports zero_signal, div_by_zero  output  1 each  result==0; divisor was 0.

Function
REQ-015 SHALL decode alu_op: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT (signed unless unsigned_op), 1001 SLTU, 0100 NOR, 0101 SLL op2<<shamt, 1000 SRL op2>>shamt, 1011 SRA op2>>>shamt, 0011 MUL, 1010 DIV; any other code yields result=0, result_hi=0.
REQ-016 SHALL implement states IDLE, EXEC, DONE; start with busy=0 in IDLE or DONE is accepted (back-to-back allowed).
REQ-017 SHALL, for single-cycle ops, register result on the accepting edge, go to DONE, and assert done in the following cycle (latency 1).
REQ-018 SHALL, for MUL/DIV with nonzero divisor, go to EXEC, perform one shift-add (MUL) or restoring-subtract (DIV) step per cycle on operand magnitudes, WIDTH steps total, then enter DONE; done asserted WIDTH edges after the accepting edge.
REQ-019 SHALL hold busy=1 exactly during EXEC (WIDTH cycles); start while busy=1 SHALL be ignored with no effect on state or outputs.
REQ-020 SHALL produce MUL as the full 2*WIDTH product: result = low half, result_hi = high half; signed when unsigned_op=0.
REQ-021 SHALL produce DIV quotient in result, remainder in result_hi; signed quotient truncates toward zero, remainder takes dividend sign.
REQ-022 SHALL apply sign correction on the final EXEC-to-DONE transition, adding no extra cycle.
REQ-023 SHALL, for signed DIV of most-negative by -1, return result = most-negative, result_hi = 0, div_by_zero=0.
REQ-024 SHALL, for DIV with operand2=0, skip EXEC (latency 1): result = all ones, result_hi = operand1, div_by_zero=1.
REQ-025 SHALL hold result, result_hi, zero_signal, div_by_zero stable from done until the next accepted start.
REQ-026 SHALL compute zero_signal from the final registered result only (not result_hi); ADD/SUB wrap modulo 2^WIDTH with no overflow flag.
REQ-027 SHALL return DONE to IDLE after one cycle when no new start is accepted.

Reset
REQ-028 SHALL, on rst=1 at any time including mid-EXEC, immediately force state IDLE, busy=0, done=0, result=0, result_hi=0, zero_signal=1, div_by_zero=0, abandoning any in-progress op.
REQ-029 SHALL accept a new start on the first rising edge after rst deasserts.

Verification (WIDTH=32)
REQ-030 SHALL cover ADD 5 + 0xFFFFFFF9 -> result 0xFFFFFFFE, zero_signal 0, done 1 cycle after accept, busy never high.
REQ-031 SHALL cover signed MUL 0xFFFFFFFD * 4 -> result 0xFFFFFFF4, result_hi 0xFFFFFFFF, busy high 32 cycles, done 32 edges after accept; unsigned 0xFFFFFFFF*0xFFFFFFFF -> hi 0xFFFFFFFE, lo 0x00000001.
REQ-032 SHALL cover DIV unsigned 100/7 -> 14 rem 2; signed 0xFFFFFFF9/2 -> 0xFFFFFFFD rem 0xFFFFFFFF; 0x80000000/0xFFFFFFFF signed -> 0x80000000 rem 0.
REQ-033 SHALL cover DIV 123/0 -> result 0xFFFFFFFF, result_hi 123, div_by_zero 1, done after 1 cycle.
REQ-034 SHALL cover rst pulse at EXEC cycle 10 of a MUL -> busy 0, done 0, result 0 immediately; subsequent SUB 9-9 -> result 0, zero_signal 1.
REQ-035 SHALL cover start with a new op during EXEC -> ignored; original MUL result delivered unchanged; start in DONE cycle accepted back-to-back.
